// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if
//   Read-side handshake bundle between the FIFO read-pointer controller and
//   its consumer / write-domain pointer source.
//   Signals:
//     rd_en        consumer read request
//     wptr_gray    Gray-coded write pointer from the write clock domain
//     rd_addr      RAM read address
//     rd_valid     RAM read data valid (one cycle after an accepted read)
//     rptr_gray    registered Gray read pointer toward the write domain
//     empty        registered FIFO empty flag
//     rd_level     registered number of entries available
//     underflow    one-cycle pulse on a read request while empty
//     almost_empty registered rd_level <= threshold (optional feature)
//   Modports:
//     master  the consumer side (drives rd_en and wptr_gray)
//     slave   the read-pointer controller
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int PTR_W  = ADDR_W + 1
);
  logic              rd_en;
  logic [PTR_W-1:0]  wptr_gray;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [PTR_W-1:0]  rptr_gray;
  logic              empty;
  logic [PTR_W-1:0]  rd_level;
  logic              underflow;
  logic              almost_empty;

  modport master (
    output rd_en,
    output wptr_gray,
    input  rd_addr,
    input  rd_valid,
    input  rptr_gray,
    input  empty,
    input  rd_level,
    input  underflow,
    input  almost_empty
  );

  modport slave (
    input  rd_en,
    input  wptr_gray,
    output rd_addr,
    output rd_valid,
    output rptr_gray,
    output empty,
    output rd_level,
    output underflow,
    output almost_empty
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read-side pointer controller of a dual-clock FIFO. Keeps the read pointer
//   in binary and Gray form, brings the write-domain Gray pointer into the
//   read clock through a two-flop synchronizer, converts it back to binary and
//   produces the registered empty / level / read-valid / underflow outputs that
//   sequence the dual-port RAM read port.
//   Ports:
//     rclk    read clock (only clock of this block)
//     rrst_n  asynchronous active-low reset
//     bus     fifo_rd_ctrl_if.slave (rd_en, wptr_gray in; rd_addr, rd_valid,
//             rptr_gray, empty, rd_level, underflow, almost_empty out)
//   Configuration macro:
//     FIFO_ALMOST_EMPTY_EN  when defined, almost_empty is a registered
//                           rd_level <= AE_THRESH flag (reset value 1);
//                           otherwise almost_empty is tied low.
module fifo_rd_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int PTR_W     = ADDR_W + 1,
  parameter int AE_THRESH = 4
) (
  input  logic          rclk,
  input  logic          rrst_n,
  fifo_rd_ctrl_if.slave bus
);

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit k of the binary value is the XOR of all Gray bits from the MSB down to k.
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b = '0;
    for (int k = 0; k < PTR_W; k++) begin
      b[k] = ^(g >> k);
    end
    return b;
  endfunction

  logic [PTR_W-1:0] wq1;
  logic [PTR_W-1:0] wq2;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] level_q;
  logic             empty_q;
  logic             rd_valid_q;
  logic             underflow_q;
  logic             acc;

  // Synchronizer stage: two back-to-back flops with nothing in between.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= bus.wptr_gray;
      wq2 <= wq1;
    end
  end

  // Next-pointer and status computation, all from rbin_next and current wq2 so
  // a read and a write-pointer advance in the same cycle are counted once.
  always_comb begin
    wbin       = gray2bin(wq2);
    acc        = bus.rd_en & ~empty_q;
    rbin_next  = acc ? rbin + PTR_W'(1) : rbin;
    rgray_next = bin2gray(rbin_next);
    level_next = wbin - rbin_next;
  end

  // Register stage: pointers and status flags.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin        <= '0;
      rgray       <= '0;
      empty_q     <= 1'b1;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rgray       <= rgray_next;
      empty_q     <= (rgray_next == wq2);
      level_q     <= level_next;
      rd_valid_q  <= acc;
      underflow_q <= bus.rd_en & empty_q;
    end
  end

`ifdef FIFO_ALMOST_EMPTY_EN
  logic ae_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      ae_q <= 1'b1;
    end else begin
      ae_q <= (level_next <= PTR_W'(AE_THRESH));
    end
  end

  assign bus.almost_empty = ae_q;
`else
  assign bus.almost_empty = 1'b0;
`endif

  assign bus.rd_addr   = rbin[ADDR_W-1:0];
  assign bus.rptr_gray = rgray;
  assign bus.empty     = empty_q;
  assign bus.rd_level  = level_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.underflow = underflow_q;

endmodule
